// File: rtl/sdram_wr_fifo_ctrl_if.sv
// Signal bundle between the write front end and its neighbours: user push port,
// burst-engine handshake and FIFO status.
interface sdram_wr_fifo_ctrl_if #(
    parameter int DATA_W  = 16,
    parameter int FIFO_AW = 10
);
    logic                init_end;
    logic                user_wr_en;
    logic [DATA_W-1:0]   user_wr_data;
    logic [9:0]          wr_burst_len_cfg;
    logic                wr_addr_rst;
    logic                wr_ack;
    logic                wr_end;

    logic                wr_en;
    logic [22:0]         wr_addr;
    logic [9:0]          wr_burst_len;
    logic [DATA_W-1:0]   wr_data;
    logic [FIFO_AW:0]    fifo_cnt;
    logic                fifo_empty;
    logic                fifo_full;
    logic                overflow;
    logic                underflow;

    modport master (
        output init_end, user_wr_en, user_wr_data, wr_burst_len_cfg, wr_addr_rst, wr_ack, wr_end,
        input  wr_en, wr_addr, wr_burst_len, wr_data, fifo_cnt, fifo_empty, fifo_full,
               overflow, underflow
    );

    modport slave (
        input  init_end, user_wr_en, user_wr_data, wr_burst_len_cfg, wr_addr_rst, wr_ack, wr_end,
        output wr_en, wr_addr, wr_burst_len, wr_data, fifo_cnt, fifo_empty, fifo_full,
               overflow, underflow
    );
endinterface

// File: rtl/sdram_wr_fifo_ctrl.sv
// SDRAM write front end: FWFT buffer of user words, burst request generation and
// linear write-address advance with wrap inside [ADDR_MIN, ADDR_MAX].
module sdram_wr_fifo_ctrl #(
    parameter int          DATA_W   = 16,
    parameter int          FIFO_AW  = 10,
    parameter logic [22:0] ADDR_MIN = 23'h000000,
    parameter logic [22:0] ADDR_MAX = 23'h7FFFFF
) (
    input logic                 sys_clk,
    input logic                 sys_rst,
    sdram_wr_fifo_ctrl_if.slave bus
);
    localparam logic [1:0]       IDLE      = 2'd0;
    localparam logic [1:0]       REQ       = 2'd1;
    localparam logic [1:0]       UPDATE    = 2'd2;
    localparam int               DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [9:0]       MAX_BURST = 10'd512;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic               empty_q, empty_d, full_q, full_d;
    logic               ovf_q, ovf_d, udf_q, udf_d;
    logic               push, pop;

    logic [1:0]         state_q, state_d;
    logic               wr_en_q, wr_en_d, pend_q, pend_d;
    logic               wr_end_d1_q, wr_end_d1_d, wr_end_rise;
    logic [22:0]        wr_addr_q, wr_addr_d;
    logic [9:0]         burst_len_q, burst_len_d, cfg_len;
    logic [23:0]        nxt_addr, nxt_last;

    // A push into a full FIFO is accepted when the same cycle pops a word.
    always_comb begin
        pop      = bus.wr_ack && !empty_q;
        push     = bus.user_wr_en && (!full_q || pop);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == FULL_CNT);
        ovf_d   = ovf_q || (bus.user_wr_en && !push);
        udf_d   = udf_q || (bus.wr_ack && empty_q);
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.user_wr_data;
        end
    end

    always_comb begin
        cfg_len     = (bus.wr_burst_len_cfg == 10'd0 || bus.wr_burst_len_cfg > MAX_BURST)
                      ? MAX_BURST : bus.wr_burst_len_cfg;
        wr_end_d1_d = bus.wr_end;
        wr_end_rise = bus.wr_end && !wr_end_d1_q;
        nxt_addr    = {1'b0, wr_addr_q} + {14'd0, burst_len_q};
        nxt_last    = nxt_addr + {14'd0, burst_len_q} - 24'd1;

        state_d     = state_q;
        wr_en_d     = wr_en_q;
        wr_addr_d   = wr_addr_q;
        burst_len_d = burst_len_q;
        pend_d      = pend_q;

        case (state_q)
            IDLE: begin
                if (bus.wr_addr_rst) begin
                    wr_addr_d = ADDR_MIN;
                    pend_d    = 1'b0;
                end
                if (bus.init_end && cnt_q >= (FIFO_AW + 1)'(cfg_len)) begin
                    burst_len_d = cfg_len;
                    wr_en_d     = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                // Address reset is deferred so the in-flight burst keeps its address.
                if (bus.wr_addr_rst) begin
                    pend_d = 1'b1;
                end
                if (wr_end_rise) begin
                    wr_en_d = 1'b0;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                state_d = IDLE;
                pend_d  = 1'b0;
                if (bus.wr_addr_rst || pend_q) begin
                    wr_addr_d = ADDR_MIN;
                end else if (nxt_last > {1'b0, ADDR_MAX}) begin
                    wr_addr_d = ADDR_MIN;
                end else begin
                    wr_addr_d = nxt_addr[22:0];
                end
            end
            default: begin
                state_d = IDLE;
                wr_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= ADDR_MIN;
            burst_len_q <= MAX_BURST;
            pend_q      <= 1'b0;
            wr_end_d1_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            burst_len_q <= burst_len_d;
            pend_q      <= pend_d;
            wr_end_d1_q <= wr_end_d1_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_burst_len = burst_len_q;
    assign bus.wr_data      = empty_q ? '0 : mem_q[rd_ptr_q];
    assign bus.fifo_cnt     = cnt_q;
    assign bus.fifo_empty   = empty_q;
    assign bus.fifo_full    = full_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sdram_wr_fifo_ctrl.sv
// Randomized bench: queue-based FIFO/address model feeds a scoreboard that a
// negedge monitor drains whenever the DUT pops a word or raises a request.
module tb_sdram_wr_fifo_ctrl;
    localparam int A_MIN = 0;
    localparam int A_MAX = 'h1F;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_wr_fifo_ctrl_if #(.DATA_W(16), .FIFO_AW(10)) bus ();

    sdram_wr_fifo_ctrl #(
        .DATA_W(16), .FIFO_AW(10), .ADDR_MIN(23'(A_MIN)), .ADDR_MAX(23'(A_MAX))
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .bus(bus)
    );

    typedef struct { int addr; int len; } req_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mq[$];
    logic [15:0] exp_pop[$];
    req_t        req_q[$];
    int          exp_addr = A_MIN;
    bit          exp_ovf = 1'b0;
    bit          exp_udf = 1'b0;

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: event with no expectation (t=%0t)", name, $time);
    endfunction

    function automatic int clamp(int cfg);
        return (cfg == 0 || cfg > 512) ? 512 : cfg;
    endfunction

    // Bursts must fit wholly inside the window; otherwise restart at the bottom.
    function automatic int next_addr(int cur, int len, bit to_min);
        if (to_min) return A_MIN;
        if (cur + 2 * len - 1 > A_MAX) return A_MIN;
        return cur + len;
    endfunction

    // Monitor: compares popped words and issued requests against the scoreboard.
    bit   en_prev = 1'b0;
    int   low_cnt = 100;
    int   prev_cnt = 0;
    bit   prev_init = 1'b0;
    req_t cur;
    always @(negedge clk) begin
        if (rst) begin
            en_prev = 1'b0;
            low_cnt = 100;
        end else begin
            if (bus.wr_ack && !bus.fifo_empty) begin
                if (exp_pop.size() == 0) fail("unexpected_pop");
                else chk("wr_data", bus.wr_data, exp_pop.pop_front());
            end
            if (bus.wr_en && !en_prev) begin
                if (req_q.size() == 0) fail("unexpected_req");
                else begin
                    cur = req_q.pop_front();
                    chk("req_addr", bus.wr_addr, cur.addr);
                    chk("req_len", bus.wr_burst_len, cur.len);
                    chk("req_cond", (prev_cnt >= cur.len) && prev_init, 1);
                    chk("req_gap", low_cnt >= 2, 1);
                end
                low_cnt = 0;
            end else if (bus.wr_en) begin
                chk("req_addr_stable", bus.wr_addr, cur.addr);
                chk("req_len_stable", bus.wr_burst_len, cur.len);
            end else begin
                low_cnt++;
            end
            en_prev = bus.wr_en;
        end
        prev_cnt  = int'(bus.fifo_cnt);
        prev_init = bus.init_end;
    end

    task automatic cycle(bit push, logic [15:0] d, bit ack, bit ars);
        bit pop_ok, push_ok;
        bus.user_wr_en   = push;
        bus.user_wr_data = d;
        bus.wr_ack       = ack;
        bus.wr_addr_rst  = ars;
        pop_ok  = ack && mq.size() > 0;
        push_ok = push && (mq.size() < DEPTH || pop_ok);
        if (ack && !pop_ok) exp_udf = 1'b1;
        if (push && !push_ok) exp_ovf = 1'b1;
        if (pop_ok) exp_pop.push_back(mq.pop_front());
        if (push_ok) mq.push_back(d);
        @(posedge clk);
        #1;
        bus.user_wr_en  = 1'b0;
        bus.wr_ack      = 1'b0;
        bus.wr_addr_rst = 1'b0;
        chk("fifo_cnt", bus.fifo_cnt, mq.size());
        chk("fifo_empty", bus.fifo_empty, mq.size() == 0);
        chk("fifo_full", bus.fifo_full, mq.size() == DEPTH);
        chk("overflow", bus.overflow, exp_ovf);
        chk("underflow", bus.underflow, exp_udf);
    endtask

    task automatic do_reset();
        bus.init_end = 1'b0; bus.user_wr_en = 1'b0; bus.user_wr_data = '0;
        bus.wr_burst_len_cfg = '0; bus.wr_addr_rst = 1'b0; bus.wr_ack = 1'b0; bus.wr_end = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        mq.delete(); exp_pop.delete(); req_q.delete();
        exp_addr = A_MIN; exp_ovf = 1'b0; exp_udf = 1'b0;
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_fifo_cnt", bus.fifo_cnt, 0);
        chk("rst_empty", bus.fifo_empty, 1);
        chk("rst_full", bus.fifo_full, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_wr_addr", bus.wr_addr, A_MIN);
        chk("rst_burst_len", bus.wr_burst_len, 512);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_underflow", bus.underflow, 0);
        rst = 1'b0;
    endtask

    task automatic wait_req(output int waited);
        waited = 0;
        while (!bus.wr_en && waited < 40) begin
            cycle(1'b0, 16'h0, 1'b0, 1'b0);
            waited++;
        end
    endtask

    task automatic end_burst(int len, bit hold, bit ars);
        if (bus.wr_end) begin
            bus.wr_end = 1'b0;
            cycle(1'b0, 16'h0, 1'b0, 1'b0);
            chk("wr_en_before_rise", bus.wr_en, 1);
        end
        bus.wr_end = 1'b1;
        cycle(1'b0, 16'h0, 1'b0, 1'b0);
        chk("wr_en_drop", bus.wr_en, 0);
        if (!hold) bus.wr_end = 1'b0;
        cycle(1'b0, 16'h0, 1'b0, 1'b0);
        exp_addr = next_addr(exp_addr, len, ars);
        chk("wr_addr_next", bus.wr_addr, exp_addr);
    endtask

    // gate: keep init_end low while filling; base: nonzero gives sequential data.
    task automatic do_burst(int cfg, bit gate, bit hold_end, bit ars_mid, bit extra,
                            int abort_after, int base);
        int   len, waited, acks, n;
        req_t r;
        len = clamp(cfg);
        bus.wr_burst_len_cfg = 10'(cfg);
        bus.init_end = !gate;
        r.addr = exp_addr;
        r.len  = len;
        req_q.push_back(r);
        n = 0;
        while (mq.size() < len) begin
            cycle(1'b1, (base != 0) ? 16'(base + n) : 16'($urandom), 1'b0, 1'b0);
            n++;
        end
        bus.init_end = 1'b1;
        wait_req(waited);
        chk("req_latency", waited, 1);
        if (gate) bus.init_end = 1'b0;
        acks = 0;
        while (acks < len) begin
            if (abort_after >= 0 && acks == abort_after) return;
            if (extra && $urandom_range(0, 2) == 0) begin
                cycle($urandom_range(0, 1) == 1 && mq.size() < 900, 16'($urandom), 1'b0, 1'b0);
            end else begin
                cycle(extra && $urandom_range(0, 1) == 1 && mq.size() < 900, 16'($urandom),
                      1'b1, ars_mid && acks == 2);
                acks++;
            end
        end
        if (bus.wr_end) begin
            repeat (3) cycle(1'b0, 16'h0, 1'b0, 1'b0);
            chk("wr_en_held_level", bus.wr_en, 1);
        end
        end_burst(len, hold_end, ars_mid);
    endtask

    initial begin
        int cfg;
        do_reset();

        // Sequential data, held wr_end, then a fresh completion edge.
        do_burst(8, 1'b0, 1'b1, 1'b0, 1'b0, -1, 1);
        do_burst(8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 9);

        // Address reset in IDLE, then three 16-word bursts wrapping a 32-word window.
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        exp_addr = A_MIN;
        chk("wr_addr_rst_idle", bus.wr_addr, exp_addr);
        repeat (3) do_burst(16, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);

        // Fill to full, drop one push, then push+pop while full, then drain.
        bus.init_end = 1'b0;
        while (mq.size() < DEPTH) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 16'hBEEF, 1'b0, 1'b0);
        cycle(1'b1, 16'h1234, 1'b1, 1'b0);
        while (mq.size() > 0) cycle(1'b0, 16'h0, 1'b1, 1'b0);
        chk("wr_data_empty", bus.wr_data, 0);

        // Ack on empty, with and without a simultaneous push.
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b1, 16'h5555, 1'b1, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0);

        // Address reset during an in-flight burst.
        do_burst(8, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0);

        repeat (10) begin
            case ($urandom_range(0, 9))
                0:       cfg = 0;
                1:       cfg = 700;
                default: cfg = $urandom_range(3, 40);
            endcase
            do_burst(cfg, 1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, 1'b1, -1, 0);
        end

        // Reset in the middle of a burst, then a cfg of 0 requests 512 words.
        do_burst(8, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0);
        do_reset();
        do_burst(0, 1'b1, 1'b0, 1'b0, 1'b0, -1, 0);

        repeat (3) cycle(1'b0, 16'h0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
